// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: load-use, branch-in-ID
// operand hazards, multi-cycle multiply in EX, plus a saturating stall counter.
module hazard_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_Mul,
  input  logic             EX_MEM_MemRead,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_Branch,
  input  logic             branch_taken,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_bubble,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MC_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MUL_CYCLES - 2);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_BR_WAIT  = 2'd1,
    S_MUL_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [MC_W-1:0]  r_mul_cnt;
  logic [MC_W-1:0]  w_mul_cnt_next;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rd_match, w_ldu, w_bra, w_brl;
  logic w_freeze, w_eval_id, w_mul_last;
  logic w_pc_write, w_if_id_write, w_id_ex_write;
  logic w_if_id_flush, w_id_ex_bubble, w_ex_mem_bubble;
  logic w_mul_busy, w_mul_done;

  // The MEM-stage operands are carried for completeness; BR_WAIT is an
  // unconditional stall so they do not steer any decision.
  logic w_unused_mem;
  assign w_unused_mem = ^{EX_MEM_MemRead, EX_MEM_Rd};

  assign w_rd_match = (ID_EX_Rd != 5'd0) &&
                      ((ID_EX_Rd == IF_ID_Rs) || (ID_EX_Rd == IF_ID_Rt));
  assign w_ldu      = ID_EX_MemRead && w_rd_match;
  assign w_bra      = IF_ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && w_rd_match;
  assign w_brl      = IF_ID_Branch && w_ldu;

  assign w_mul_last = (r_state == S_MUL_WAIT) && (r_mul_cnt == '0);
  assign w_freeze   = ((r_state == S_RUN) && ID_EX_Mul) ||
                      ((r_state == S_MUL_WAIT) && (r_mul_cnt != '0));
  // ID hazards are judged in RUN and again on the cycle the multiply releases EX.
  assign w_eval_id  = ((r_state == S_RUN) && !ID_EX_Mul) || w_mul_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_mul_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_mul_cnt <= w_mul_cnt_next;
      if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_mul_cnt_next = r_mul_cnt;
    case (r_state)
      S_RUN: begin
        if (ID_EX_Mul) begin
          w_state_next   = S_MUL_WAIT;
          w_mul_cnt_next = MC_LOAD;
        end else if (w_brl) begin
          w_state_next = S_BR_WAIT;
        end
      end
      S_BR_WAIT: w_state_next = S_RUN;
      S_MUL_WAIT: begin
        if (r_mul_cnt != '0)
          w_mul_cnt_next = r_mul_cnt - MC_W'(1);
        else if (w_brl)
          w_state_next = S_BR_WAIT;
        else
          w_state_next = S_RUN;
      end
      default: w_state_next = S_RUN;
    endcase
  end

  always_comb begin
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_id_ex_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_bubble  = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_mul_busy      = 1'b0;
    w_mul_done      = w_mul_last;
    if (w_freeze) begin
      w_pc_write      = 1'b0;
      w_if_id_write   = 1'b0;
      w_id_ex_write   = 1'b0;
      w_ex_mem_bubble = 1'b1;
      w_mul_busy      = 1'b1;
    end
    if (r_state == S_BR_WAIT || (w_eval_id && (w_brl || w_ldu || w_bra))) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_bubble = 1'b1;
    end else if (w_eval_id && IF_ID_Branch && branch_taken) begin
      w_if_id_flush = 1'b1;
    end
  end

  // Every output, enables included, reads as 0 while reset is held.
  assign PC_write      = rst & w_pc_write;
  assign IF_ID_write   = rst & w_if_id_write;
  assign ID_EX_write   = rst & w_id_ex_write;
  assign IF_ID_flush   = rst & w_if_id_flush;
  assign ID_EX_bubble  = rst & w_id_ex_bubble;
  assign EX_MEM_bubble = rst & w_ex_mem_bubble;
  assign mul_busy      = rst & w_mul_busy;
  assign mul_done      = rst & w_mul_done;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer (MUL_CYCLES=4, CNT_W=4); outputs packed as
// {PC_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_bubble, EX_MEM_bubble, mul_busy, mul_done}.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Mul;
  logic [4:0] ID_EX_Rd;
  logic       EX_MEM_MemRead;
  logic [4:0] EX_MEM_Rd;
  logic [4:0] IF_ID_Rs, IF_ID_Rt;
  logic       IF_ID_Branch, branch_taken;
  logic       PC_write, IF_ID_write, ID_EX_write, IF_ID_flush;
  logic       ID_EX_bubble, EX_MEM_bubble, mul_busy, mul_done;
  logic [3:0] stall_cnt;
  logic [7:0] outs;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [7:0] O_RUN    = 8'b1110_0000;
  localparam logic [7:0] O_STALL  = 8'b0010_1000;
  localparam logic [7:0] O_FLUSH  = 8'b1111_0000;
  localparam logic [7:0] O_FREEZE = 8'b0000_0110;
  localparam logic [7:0] O_DONE   = 8'b1110_0001;
  localparam logic [7:0] O_DONE_S = 8'b0010_1001;

  always #5 clk = ~clk;

  hazard_sequencer #(.MUL_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_Mul(ID_EX_Mul),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_Rd(EX_MEM_Rd),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .IF_ID_Branch(IF_ID_Branch), .branch_taken(branch_taken),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble),
    .EX_MEM_bubble(EX_MEM_bubble), .mul_busy(mul_busy), .mul_done(mul_done),
    .stall_cnt(stall_cnt)
  );

  assign outs = {PC_write, IF_ID_write, ID_EX_write, IF_ID_flush,
                 ID_EX_bubble, EX_MEM_bubble, mul_busy, mul_done};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    $display("check %-14s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic clr_inputs();
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_Mul = 0; ID_EX_Rd = 0;
    EX_MEM_MemRead = 0; EX_MEM_Rd = 0; IF_ID_Rs = 0; IF_ID_Rt = 0;
    IF_ID_Branch = 0; branch_taken = 0;
  endtask

  // Advance one edge and land 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle reset pulse; leaves inputs cleared.
  task automatic do_reset();
    clr_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    clr_inputs();
    rst = 1'b0;
    ID_EX_Mul = 1;
    #12;
    chk("rst_outs", outs, 8'h00);
    chk("rst_cnt", {4'b0, stall_cnt}, 8'd0);
    rst = 1'b1;
    #1;
    chk("rel_mul_run", outs, O_FREEZE);
    tick(); ID_EX_Mul = 0; #1;
    chk("rel_mulwait1", outs, O_FREEZE);
    chk("rel_cnt1", {4'b0, stall_cnt}, 8'd1);
    tick(); #1;
    chk("rel_mulwait2", outs, O_FREEZE);
    tick(); #1;
    chk("rel_done", outs, O_DONE);
    tick(); #1;
    chk("rel_run", outs, O_RUN);
    chk("rel_cnt3", {4'b0, stall_cnt}, 8'd3);

    // Load-use: lw $5 in EX, add using $5 in ID.
    tick(); do_reset();
    ID_EX_MemRead = 1; ID_EX_Rd = 5; IF_ID_Rs = 5; IF_ID_Rt = 2; #1;
    chk("ldu_stall", outs, O_STALL);
    tick(); ID_EX_MemRead = 0; ID_EX_Rd = 0; #1;
    chk("ldu_resume", outs, O_RUN);
    chk("ldu_cnt", {4'b0, stall_cnt}, 8'd1);
    ID_EX_MemRead = 1; ID_EX_Rd = 0; IF_ID_Rs = 0; IF_ID_Rt = 0; #1;
    chk("ldu_r0", outs, O_RUN);
    tick();
    chk("ldu_r0_cnt", {4'b0, stall_cnt}, 8'd1);

    // Load->branch: lw $3 in EX, beq $3,$4 taken in ID.
    do_reset();
    ID_EX_MemRead = 1; ID_EX_Rd = 3; IF_ID_Rs = 3; IF_ID_Rt = 4;
    IF_ID_Branch = 1; branch_taken = 1; #1;
    chk("brl_stall1", outs, O_STALL);
    tick(); ID_EX_MemRead = 0; ID_EX_Rd = 0; EX_MEM_MemRead = 1; EX_MEM_Rd = 3; #1;
    chk("brl_stall2", outs, O_STALL);
    tick(); EX_MEM_MemRead = 0; EX_MEM_Rd = 0; #1;
    chk("brl_flush", outs, O_FLUSH);
    chk("brl_cnt", {4'b0, stall_cnt}, 8'd2);
    tick(); IF_ID_Branch = 0; branch_taken = 0; #1;
    chk("brl_after", outs, O_RUN);

    // ALU->branch: add $7 in EX, bne $7 in ID.
    tick(); do_reset();
    ID_EX_RegWrite = 1; ID_EX_Rd = 7; IF_ID_Rs = 7; IF_ID_Rt = 1;
    IF_ID_Branch = 1; branch_taken = 1; #1;
    chk("bra_stall", outs, O_STALL);
    tick(); ID_EX_RegWrite = 0; ID_EX_Rd = 0; #1;
    chk("bra_flush", outs, O_FLUSH);
    tick(); ID_EX_RegWrite = 1; ID_EX_Rd = 7; branch_taken = 0; #1;
    chk("bra_nt_stall", outs, O_STALL);
    tick(); ID_EX_RegWrite = 0; ID_EX_Rd = 0; #1;
    chk("bra_nt_noflush", outs, O_RUN);
    chk("bra_cnt", {4'b0, stall_cnt}, 8'd2);

    // Back-to-back multiplies: 8 cycles, two mul_done pulses.
    tick(); do_reset();
    IF_ID_Branch = 0;
    ID_EX_Mul = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("b2b_cyc%0d", i), outs, ((i % 4) == 3) ? O_DONE : O_FREEZE);
      tick();
    end
    ID_EX_Mul = 0; #1;
    chk("b2b_end", outs, O_RUN);
    chk("b2b_cnt", {4'b0, stall_cnt}, 8'd6);

    // Load-use pending during a freeze is honoured on the mul_done cycle.
    tick(); do_reset();
    ID_EX_Mul = 1; #1;
    chk("mldu_run", outs, O_FREEZE);
    tick(); ID_EX_Mul = 0; ID_EX_MemRead = 1; ID_EX_Rd = 9; IF_ID_Rs = 9; #1;
    chk("mldu_frz1", outs, O_FREEZE);
    tick(); #1;
    chk("mldu_frz2", outs, O_FREEZE);
    tick(); #1;
    chk("mldu_done", outs, O_DONE_S);
    tick(); ID_EX_MemRead = 0; ID_EX_Rd = 0; #1;
    chk("mldu_after", outs, O_RUN);
    chk("mldu_cnt", {4'b0, stall_cnt}, 8'd4);

    // Saturation of the 4-bit counter under 20 stall cycles.
    tick(); do_reset();
    ID_EX_MemRead = 1; ID_EX_Rd = 5; IF_ID_Rs = 5;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("sat_14", {4'b0, stall_cnt}, 8'd14);
      if (i == 15) chk("sat_15", {4'b0, stall_cnt}, 8'd15);
    end
    chk("sat_hold", {4'b0, stall_cnt}, 8'd15);
    chk("sat_stall", outs, O_STALL);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

- Sequential stall/flush controller for the 5-stage MIPS pipeline.
- Sits beside the forwarding logic and drives the PC, IF/ID, ID/EX and EX/MEM pipeline-register enables and flushes.
- Covers hazards forwarding cannot fix: load-use, branch-resolved-in-ID operand dependencies (including the two-cycle load→branch case), and a multi-cycle multiplier occupying EX.
- Keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MUL_CYCLES, 4, total cycles a multiply occupies EX; legal range ≥2
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_RegWrite  input  1  instruction in EX writes a register
- ID_EX_Rd  input  5  EX destination register (after RegDst mux)
- ID_EX_Mul  input  1  instruction in EX is a multiply
- EX_MEM_MemRead  input  1  instruction in MEM is a load
- EX_MEM_Rd  input  5  MEM destination register
- IF_ID_Rs, IF_ID_Rt  input  5 each  source registers of the instruction in ID
- IF_ID_Branch  input  1  instruction in ID is a conditional branch
- branch_taken  input  1  branch comparison result in ID
- PC_write, IF_ID_write, ID_EX_write  output  1 each  register enables; 1 = advance
- IF_ID_flush  output  1  zero IF/ID (squash fetched instruction)
- ID_EX_bubble  output  1  load NOP control into ID/EX
- EX_MEM_bubble  output  1  load NOP control into EX/MEM
- mul_busy  output  1  multiply occupying EX
- mul_done  output  1  one-cycle pulse: multiply result valid, EX releases
- stall_cnt  output  CNT_W  count of cycles with PC_write=0

## Operation
States: RUN, BR_WAIT, MUL_WAIT. Register mul_cnt sized ⌈log2 MUL_CYCLES⌉. Outputs are combinational from state and inputs.

Hazard terms:
- ldu = ID_EX_MemRead & ID_EX_Rd≠0 & (ID_EX_Rd==IF_ID_Rs | ID_EX_Rd==IF_ID_Rt)
- bra = IF_ID_Branch & ID_EX_RegWrite & ~ID_EX_MemRead & ID_EX_Rd≠0 & Rd matches Rs or Rt
- brl = IF_ID_Branch & ldu

Defaults: all enables 1, all flush/bubble 0.

A stall means PC_write = IF_ID_write = 0, ID_EX_bubble = 1.

RUN, evaluated in priority order:
1. ID_EX_Mul: freeze PC, IF/ID and ID/EX (all enables 0); EX_MEM_bubble=1; mul_busy=1; mul_cnt←MUL_CYCLES−2; go to MUL_WAIT.
2. brl: stall; go to BR_WAIT.
3. ldu or bra: stall one cycle; stay in RUN.
4. IF_ID_Branch & branch_taken: IF_ID_flush=1, PC advances to target; stay in RUN.

BR_WAIT (load now in MEM):
- Unconditional stall; go to RUN.
- In RUN the loaded value reaches ID through write-first register file bypass.

MUL_WAIT:
- mul_cnt≠0: freeze as in RUN rule 1; mul_busy=1; mul_cnt decrements.
- mul_cnt==0: mul_done=1, mul_busy=0, EX/MEM captures the result. Hazard rules 2–4 apply to ID this cycle; rule 1 does not. Go to RUN.
- Back-to-back multiplies re-enter through rule 1 on the next cycle.

Counter:
- stall_cnt increments on every cycle with PC_write=0, including multiply freeze cycles.
- Saturates at 2^CNT_W−1; never wraps.

## Timing
- Reset (rst=0, asynchronous): state RUN, mul_cnt 0, stall_cnt 0. While rst=0, every output is forced to 0 (including the enables). Reset mid-multiply or mid-BR_WAIT aborts immediately.
- First edge after rst deasserts: normal RUN evaluation.
- Stall outputs are same-cycle (Mealy) with their hazard inputs.
- Latencies: load-use costs 1 cycle; ALU→branch costs 1 cycle; load→branch costs 2 cycles; a multiply holds EX for exactly MUL_CYCLES cycles (1 RUN + MUL_CYCLES−1 MUL_WAIT), with mul_done in the last one.
- Register $0 never creates a hazard.
- IF_ID_flush is never asserted together with a stall.

## Test plan
- Reset: hold rst=0 with ID_EX_Mul=1 → all outputs 0, stall_cnt=0; release rst → cycle 1 enters MUL_WAIT.
- Load-use: lw $5 in EX, add using $5 in ID → exactly one cycle of PC_write=0 and ID_EX_bubble=1; stall_cnt=1; a load to $0 causes no stall.
- Load→branch: lw $3 in EX, beq $3,$4 in ID taken → 2 stall cycles (RUN, then BR_WAIT), then IF_ID_flush=1 for 1 cycle; stall_cnt=2.
- ALU→branch: add $7 in EX, bne $7 in ID → 1 stall cycle, then flush if taken; a not-taken branch causes no flush.
- Multiply, MUL_CYCLES=4: ID_EX_Mul=1 → 3 frozen cycles with EX_MEM_bubble=1, mul_done in cycle 4; back-to-back multiplies → 8 cycles, 2 mul_done pulses; an ID load-use pending during the freeze is honoured on the mul_done cycle.
- Saturation, CNT_W=4: 20 stall cycles → stall_cnt holds at 15.
